// File: rtl/issue_queue.sv
// Instruction issue queue: buffers decoded instructions in a circular FIFO and
// dispatches the head each cycle to the ROB plus either the RS or the LSB.
module issue_queue #(
  parameter int DEPTH   = 4,
  parameter int ROB_LOG = 4,
  parameter int OP_LOG  = 6
) (
  input  logic               clk_in,
  input  logic               rst_n,
  input  logic               rdy_in,
  input  logic               clear,
  input  logic               dec_valid,
  input  logic [OP_LOG-1:0]  dec_op,
  input  logic [4:0]         dec_rd,
  input  logic [4:0]         dec_rs1,
  input  logic [4:0]         dec_rs2,
  input  logic [31:0]        dec_imm,
  input  logic [31:0]        dec_pc,
  input  logic               dec_is_ls,
  input  logic               dec_has_rd,
  output logic               dec_ready,
  input  logic               rob_full,
  input  logic               rs_full,
  input  logic               lsb_full,
  input  logic [ROB_LOG-1:0] rob_next,
  output logic [4:0]         rs1_to_reg,
  output logic [4:0]         rs2_to_reg,
  input  logic [31:0]        Vj_from_reg,
  input  logic [31:0]        Vk_from_reg,
  input  logic               Rj_from_reg,
  input  logic               Rk_from_reg,
  input  logic [ROB_LOG-1:0] Qj_from_reg,
  input  logic [ROB_LOG-1:0] Qk_from_reg,
  output logic               rob_send_enable,
  output logic [OP_LOG-1:0]  rob_send_op,
  output logic [4:0]         rob_send_dest,
  output logic               reg_send_enable,
  output logic [4:0]         reg_send_index,
  output logic [ROB_LOG-1:0] send_RobId,
  output logic               rs_send_enable,
  output logic [OP_LOG-1:0]  rs_send_op,
  output logic [31:0]        rs_send_Vj,
  output logic               rs_send_Rj,
  output logic [ROB_LOG-1:0] rs_send_Qj,
  output logic [31:0]        rs_send_Vk,
  output logic               rs_send_Rk,
  output logic [ROB_LOG-1:0] rs_send_Qk,
  output logic [31:0]        rs_send_Imm,
  output logic [31:0]        rs_send_CurPc,
  output logic               lsb_send_enable,
  output logic [OP_LOG-1:0]  lsb_send_op,
  output logic [31:0]        lsb_send_Vj,
  output logic               lsb_send_Rj,
  output logic [ROB_LOG-1:0] lsb_send_Qj,
  output logic [31:0]        lsb_send_Vk,
  output logic               lsb_send_Rk,
  output logic [ROB_LOG-1:0] lsb_send_Qk,
  output logic [31:0]        lsb_send_Imm
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  typedef struct packed {
    logic [OP_LOG-1:0] op;
    logic [4:0]        rd;
    logic [4:0]        rs1;
    logic [4:0]        rs2;
    logic [31:0]       imm;
    logic [31:0]       pc;
    logic              is_ls;
    logic              has_rd;
  } entry_t;

  entry_t           entries_q [DEPTH];
  entry_t           head_e;
  logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             push, fire;

  assign head_e    = entries_q[head_q];
  assign dec_ready = rst_n && rdy_in && !clear && (count_q < DEPTH_C);
  assign push      = dec_valid && dec_ready;
  assign fire      = rdy_in && !clear && (count_q != '0) && !rob_full &&
                     (head_e.is_ls ? !lsb_full : !rs_full);

  // A stalled (rdy_in low) cycle also ignores clear, so every piece of state freezes.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (rdy_in && clear) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (push) tail_d = tail_q + PTR_W'(1);
      if (fire) head_d = head_q + PTR_W'(1);
      if (push && !fire)      count_d = count_q + CNT_W'(1);
      else if (fire && !push) count_d = count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk_in) begin
    if (push) begin
      entries_q[tail_q] <= '{op: dec_op, rd: dec_rd, rs1: dec_rs1, rs2: dec_rs2,
                             imm: dec_imm, pc: dec_pc, is_ls: dec_is_ls,
                             has_rd: dec_has_rd};
    end
  end

  assign rs1_to_reg      = head_e.rs1;
  assign rs2_to_reg      = head_e.rs2;

  assign rob_send_enable = fire;
  assign rob_send_op     = head_e.op;
  assign rob_send_dest   = head_e.rd;
  assign send_RobId      = rob_next;
  assign reg_send_enable = fire && head_e.has_rd && (head_e.rd != 5'd0);
  assign reg_send_index  = head_e.rd;

  assign rs_send_enable  = fire && !head_e.is_ls;
  assign rs_send_op      = head_e.op;
  assign rs_send_Vj      = Vj_from_reg;
  assign rs_send_Rj      = Rj_from_reg;
  assign rs_send_Qj      = Qj_from_reg;
  assign rs_send_Vk      = Vk_from_reg;
  assign rs_send_Rk      = Rk_from_reg;
  assign rs_send_Qk      = Qk_from_reg;
  assign rs_send_Imm     = head_e.imm;
  assign rs_send_CurPc   = head_e.pc;

  assign lsb_send_enable = fire && head_e.is_ls;
  assign lsb_send_op     = head_e.op;
  assign lsb_send_Vj     = Vj_from_reg;
  assign lsb_send_Rj     = Rj_from_reg;
  assign lsb_send_Qj     = Qj_from_reg;
  assign lsb_send_Vk     = Vk_from_reg;
  assign lsb_send_Rk     = Rk_from_reg;
  assign lsb_send_Qk     = Qk_from_reg;
  assign lsb_send_Imm    = head_e.imm;

endmodule
